// File: rtl/emu_time_mgr.sv
// emu_time_mgr: picks the smallest timestep requested by N requesters, commits
// it once per emulation clock and accumulates it into a saturating time counter.
// clk_vals flags every requester whose request equals the committed step.
// Optional feature: define EMU_STOP_TIME_EN to add the stop_time port and the
// DONE state, which clips the final step so emu_time lands exactly on stop_time.
module emu_time_mgr #(
    parameter int N          = 2,
    parameter int DT_WIDTH   = 24,
    parameter int TIME_WIDTH = 40
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst_n,
    input  logic                  run,
    input  logic [DT_WIDTH-1:0]   dt_req [N],
`ifdef EMU_STOP_TIME_EN
    input  logic [TIME_WIDTH-1:0] stop_time,
`endif
    output logic [DT_WIDTH-1:0]   emu_dt,
    output logic [TIME_WIDTH-1:0] emu_time,
    output logic                  clk_vals [N],
    output logic [1:0]            state,
    output logic                  ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // Zero-extension widths for mixing step-sized and time-sized operands.
    localparam int SUM_PAD = TIME_WIDTH + 1 - DT_WIDTH;
`ifdef EMU_STOP_TIME_EN
    localparam int DT_PAD  = TIME_WIDTH - DT_WIDTH;
`endif

    state_t                cur_state;
    state_t                nxt_state;
    logic [DT_WIDTH-1:0]   dt_min;
    logic [TIME_WIDTH:0]   sum_wide;
    logic [DT_WIDTH-1:0]   nxt_dt;
    logic [TIME_WIDTH-1:0] nxt_time;
    logic                  nxt_clk [N];
    logic                  nxt_ovf;
`ifdef EMU_STOP_TIME_EN
    logic [TIME_WIDTH-1:0] gap;
`endif

    assign state = cur_state;

    // One extra bit catches the carry out of the accumulator for saturation.
    assign sum_wide = {1'b0, emu_time} + {{SUM_PAD{1'b0}}, dt_min};

`ifdef EMU_STOP_TIME_EN
    // Distance to the stop threshold; only meaningful while emu_time < stop_time.
    assign gap = stop_time - emu_time;
`endif

    // Unsigned minimum over all requested timesteps.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // the running minimum; sequential blocks below use '<=' instead.
        dt_min = dt_req[0];
        for (int k = 1; k < N; k++) begin
            if (dt_req[k] < dt_min) begin
                dt_min = dt_req[k];
            end
        end
    end

    // Next-state and next-output logic; a step is committed only from RUN.
    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves one unassigned, which would infer a latch.
        nxt_state = cur_state;
        nxt_dt    = '0;
        nxt_time  = emu_time;
        nxt_ovf   = ovf;
        for (int k = 0; k < N; k++) begin
            nxt_clk[k] = 1'b0;
        end

        unique case (cur_state)
            IDLE: begin
                if (run) begin
                    nxt_state = RUN;
                end
            end

            HOLD: begin
                if (run) begin
                    nxt_state = RUN;
                end
            end

            RUN: begin
                if (!run) begin
                    nxt_state = HOLD;
                end
                nxt_dt = dt_min;
                for (int k = 0; k < N; k++) begin
                    nxt_clk[k] = (dt_req[k] == dt_min);
                end
                if (sum_wide[TIME_WIDTH]) begin
                    nxt_time = '1;
                    nxt_ovf  = 1'b1;
                end else begin
                    nxt_time = sum_wide[TIME_WIDTH-1:0];
                end
`ifdef EMU_STOP_TIME_EN
                if (emu_time >= stop_time) begin
                    // Already at or past the threshold: finish without stepping.
                    nxt_state = DONE;
                    nxt_dt    = '0;
                    nxt_time  = emu_time;
                    nxt_ovf   = ovf;
                    for (int k = 0; k < N; k++) begin
                        nxt_clk[k] = 1'b0;
                    end
                end else if (sum_wide >= {1'b0, stop_time}) begin
                    // Clip the final step; gap <= dt_min so it fits DT_WIDTH.
                    nxt_state = DONE;
                    nxt_dt    = gap[DT_WIDTH-1:0];
                    nxt_time  = stop_time;
                    nxt_ovf   = ovf;
                    for (int k = 0; k < N; k++) begin
                        nxt_clk[k] = ({{DT_PAD{1'b0}}, dt_req[k]} == gap);
                    end
                end
`endif
            end

            default: begin
                // DONE is terminal until reset.
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge emu_clk) begin
        if (!emu_rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Committed-step registers; reset discards any step in flight.
    always_ff @(posedge emu_clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge values, independent of statement order.
        if (!emu_rst_n) begin
            emu_dt   <= '0;
            emu_time <= '0;
            ovf      <= 1'b0;
            for (int k = 0; k < N; k++) begin
                clk_vals[k] <= 1'b0;
            end
        end else begin
            emu_dt   <= nxt_dt;
            emu_time <= nxt_time;
            ovf      <= nxt_ovf;
            for (int k = 0; k < N; k++) begin
                clk_vals[k] <= nxt_clk[k];
            end
        end
    end

    // Once set, the overflow flag only clears through reset.
    ovf_sticky_a: assert property (@(posedge emu_clk) disable iff (!emu_rst_n)
        ovf |=> ovf);

endmodule

// File: tb/tb_emu_time_mgr.sv
// tb_emu_time_mgr: directed-vector bench for emu_time_mgr. A default-sized
// instance covers min selection, ties, zero steps, hold, reset and the optional
// stop threshold; an 8-bit-time instance covers accumulator saturation.
module tb_emu_time_mgr;

    logic        emu_clk;
    logic        emu_rst_n;

    // Default-sized instance (N=2, DT_WIDTH=24, TIME_WIDTH=40).
    logic        run;
    logic [23:0] dt_req [2];
    logic [23:0] emu_dt;
    logic [39:0] emu_time;
    logic        clk_vals [2];
    logic [1:0]  state;
    logic        ovf;

    // Narrow instance (N=2, DT_WIDTH=6, TIME_WIDTH=8) for saturation.
    logic        s_run;
    logic [5:0]  s_dt_req [2];
    logic [5:0]  s_emu_dt;
    logic [7:0]  s_emu_time;
    logic        s_clk_vals [2];
    logic [1:0]  s_state;
    logic        s_ovf;

`ifdef EMU_STOP_TIME_EN
    logic [39:0] stop_time;
    logic [7:0]  s_stop_time;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [68:0] obs;
    logic [68:0] exp_v;
    logic [18:0] s_obs;
    logic [18:0] s_exp;

    emu_time_mgr #(.N(2), .DT_WIDTH(24), .TIME_WIDTH(40)) dut (
        .emu_clk   (emu_clk),
        .emu_rst_n (emu_rst_n),
        .run       (run),
        .dt_req    (dt_req),
`ifdef EMU_STOP_TIME_EN
        .stop_time (stop_time),
`endif
        .emu_dt    (emu_dt),
        .emu_time  (emu_time),
        .clk_vals  (clk_vals),
        .state     (state),
        .ovf       (ovf)
    );

    emu_time_mgr #(.N(2), .DT_WIDTH(6), .TIME_WIDTH(8)) dut_small (
        .emu_clk   (emu_clk),
        .emu_rst_n (emu_rst_n),
        .run       (s_run),
        .dt_req    (s_dt_req),
`ifdef EMU_STOP_TIME_EN
        .stop_time (s_stop_time),
`endif
        .emu_dt    (s_emu_dt),
        .emu_time  (s_emu_time),
        .clk_vals  (s_clk_vals),
        .state     (s_state),
        .ovf       (s_ovf)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    // Observed vectors: {state, emu_dt, emu_time, clk_vals[1], clk_vals[0], ovf}.
    function automatic logic [68:0] main_obs();
        return {state, emu_dt, emu_time, clk_vals[1], clk_vals[0], ovf};
    endfunction

    function automatic logic [68:0] main_exp(input logic [1:0] st, input logic [23:0] dt,
                                             input logic [39:0] tm, input logic c0,
                                             input logic c1, input logic ov);
        return {st, dt, tm, c1, c0, ov};
    endfunction

    function automatic logic [18:0] small_obs();
        return {s_state, s_emu_dt, s_emu_time, s_clk_vals[1], s_clk_vals[0], s_ovf};
    endfunction

    function automatic logic [18:0] small_exp(input logic [1:0] st, input logic [5:0] dt,
                                              input logic [7:0] tm, input logic c0,
                                              input logic c1, input logic ov);
        return {st, dt, tm, c1, c0, ov};
    endfunction

    // Advance one edge and settle past it before sampling.
    task automatic tick();
        @(posedge emu_clk);
        #1;
    endtask

    task automatic test_reset();
        emu_rst_n   = 1'b0;
        run         = 1'b0;
        s_run       = 1'b0;
        dt_req[0]   = 24'd5;
        dt_req[1]   = 24'd3;
        s_dt_req[0] = 6'd10;
        s_dt_req[1] = 6'd12;
`ifdef EMU_STOP_TIME_EN
        stop_time   = '1;
        s_stop_time = '1;
`endif
        tick();
        tick();
        obs = main_obs(); exp_v = main_exp(2'd0, 24'd0, 40'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_main: got %h expected %h", obs, exp_v);
        end
        s_obs = small_obs(); s_exp = small_exp(2'd0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (s_obs !== s_exp) begin
            errors++;
            $display("FAIL reset_small: got %h expected %h", s_obs, s_exp);
        end
        emu_rst_n = 1'b1;
    endtask

    // dt_req = {5, 3}: requester 1 owns every step, time grows by 3.
    task automatic test_min_select();
        run = 1'b1;
        tick();
        obs = main_obs(); exp_v = main_exp(2'd1, 24'd0, 40'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL idle_to_run: got %h expected %h", obs, exp_v);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            obs = main_obs(); exp_v = main_exp(2'd1, 24'd3, 40'(3 * i), 1'b0, 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL min_step%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    // dt_req = {7, 7}: both requesters own the step.
    task automatic test_tie();
        dt_req[0] = 24'd7;
        dt_req[1] = 24'd7;
        for (int i = 1; i <= 2; i++) begin
            tick();
            obs = main_obs(); exp_v = main_exp(2'd1, 24'd7, 40'(12 + 7 * i), 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL tie_step%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    // dt_req = {0, 4}: zero step is legal; then run low for three edges.
    task automatic test_zero_and_hold();
        dt_req[0] = 24'd0;
        dt_req[1] = 24'd4;
        for (int i = 1; i <= 2; i++) begin
            tick();
            obs = main_obs(); exp_v = main_exp(2'd1, 24'd0, 40'd26, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL zero_step%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        run       = 1'b0;
        dt_req[0] = 24'd5;
        // The edge that sees run low still commits the step in flight.
        tick();
        obs = main_obs(); exp_v = main_exp(2'd2, 24'd4, 40'd30, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_enter: got %h expected %h", obs, exp_v);
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
            obs = main_obs(); exp_v = main_exp(2'd2, 24'd0, 40'd30, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hold_frozen%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        run = 1'b1;
        tick();
        obs = main_obs(); exp_v = main_exp(2'd1, 24'd0, 40'd30, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_to_run: got %h expected %h", obs, exp_v);
        end
        tick();
        obs = main_obs(); exp_v = main_exp(2'd1, 24'd4, 40'd34, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL resume_step: got %h expected %h", obs, exp_v);
        end
    endtask

    // Reset while running at emu_time = 12, then restart from zero.
    task automatic test_reset_mid_run();
        emu_rst_n = 1'b0;
        tick();
        obs = main_obs(); exp_v = main_exp(2'd0, 24'd0, 40'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_clear: got %h expected %h", obs, exp_v);
        end
        emu_rst_n = 1'b1;
        dt_req[0] = 24'd4;
        dt_req[1] = 24'd6;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
        end
        obs = main_obs(); exp_v = main_exp(2'd1, 24'd4, 40'd12, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_rst_time12: got %h expected %h", obs, exp_v);
        end
        emu_rst_n = 1'b0;
        tick();
        obs = main_obs(); exp_v = main_exp(2'd0, 24'd0, 40'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_mid_run: got %h expected %h", obs, exp_v);
        end
        emu_rst_n = 1'b1;
        tick();
        tick();
        obs = main_obs(); exp_v = main_exp(2'd1, 24'd4, 40'd4, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL post_rst_step: got %h expected %h", obs, exp_v);
        end
        run = 1'b0;
    endtask

    // 8-bit time: 25 steps of 10 reach 250, the next step would pass 255.
    task automatic test_overflow();
        s_run = 1'b1;
        tick();
        for (int i = 1; i <= 25; i++) begin
            tick();
        end
        s_obs = small_obs(); s_exp = small_exp(2'd1, 6'd10, 8'd250, 1'b1, 1'b0, 1'b0);
        checks++;
        if (s_obs !== s_exp) begin
            errors++;
            $display("FAIL sat_at250: got %h expected %h", s_obs, s_exp);
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
`ifdef EMU_STOP_TIME_EN
            // stop_time = 255 clips the step before the accumulator can overflow.
            if (i == 1) s_exp = small_exp(2'd3, 6'd5, 8'd255, 1'b0, 1'b0, 1'b0);
            else        s_exp = small_exp(2'd3, 6'd0, 8'd255, 1'b0, 1'b0, 1'b0);
`else
            s_exp = small_exp(2'd1, 6'd10, 8'd255, 1'b1, 1'b0, 1'b1);
`endif
            s_obs = small_obs();
            checks++;
            if (s_obs !== s_exp) begin
                errors++;
                $display("FAIL sat_step%0d: got %h expected %h", i, s_obs, s_exp);
            end
        end
        s_run     = 1'b0;
        emu_rst_n = 1'b0;
        tick();
        s_obs = small_obs(); s_exp = small_exp(2'd0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (s_obs !== s_exp) begin
            errors++;
            $display("FAIL sat_rst_clear: got %h expected %h", s_obs, s_exp);
        end
        emu_rst_n = 1'b1;
    endtask

`ifdef EMU_STOP_TIME_EN
    // stop_time = 20 with dt_req = {6, 9}: 6, 12, 18, then a clipped step of 2.
    task automatic test_stop_time();
        emu_rst_n = 1'b0;
        stop_time = 40'd20;
        tick();
        emu_rst_n = 1'b1;
        dt_req[0] = 24'd6;
        dt_req[1] = 24'd9;
        run       = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            obs = main_obs(); exp_v = main_exp(2'd1, 24'd6, 40'(6 * i), 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stop_step%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        tick();
        obs = main_obs(); exp_v = main_exp(2'd3, 24'd2, 40'd20, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL stop_clip: got %h expected %h", obs, exp_v);
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
            obs = main_obs(); exp_v = main_exp(2'd3, 24'd0, 40'd20, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stop_done%0d: got %h expected %h", i, obs, exp_v);
            end
            run = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_min_select();
        test_tie();
        test_zero_and_hold();
        test_reset_mid_run();
        test_overflow();
`ifdef EMU_STOP_TIME_EN
        test_stop_time();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
